// File: rtl/spmm_out_buffer_if.sv
// Bundle of handshake and data signals between the SpMM reduction unit,
// the output buffer and the drain consumer.
//
// Ports (signals):
//   in_valid, in_col, in_os, in_data  column write request (producer -> buffer)
//   in_ready                          buffer can accept a column
//   out_ready                         every column written since the last drain
//   out_start                         consumer asks for a drain
//   out_valid, out_data, beat_idx     drain beats (4 columns per beat)
//
// Modports: master = producer/consumer side, slave = buffer side.
interface spmm_out_buffer_if #(
    parameter int N   = 16,
    parameter int W   = 8,
    parameter int LGN = $clog2(N)
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LGN-1:0]               in_col;
    logic                         in_os;
    logic [N-1:0][W-1:0]          in_data;
    logic                         out_ready;
    logic                         out_start;
    logic                         out_valid;
    logic [3:0][N-1:0][W-1:0]     out_data;
    logic [LGN-3:0]               beat_idx;

    modport master (
        output in_valid, in_col, in_os, in_data, out_start,
        input  in_ready, out_ready, out_valid, out_data, beat_idx
    );

    modport slave (
        input  in_valid, in_col, in_os, in_data, out_start,
        output in_ready, out_ready, out_valid, out_data, beat_idx
    );
endinterface

// File: rtl/spmm_out_buffer.sv
// SpMM output buffer. Collects one N-element result column per accepted
// transfer into an N x N buffer (overwrite or accumulate), and once every
// column has been written drains the buffer four columns per cycle.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low; clears buffer and all state
//   bus    spmm_out_buffer_if.slave (column writes in, drain beats out)
//
// Build option: define SPMM_OUTBUF_SAT_EN to make accumulation unsigned
// saturating instead of wrapping modulo 2^W.
module spmm_out_buffer #(
    parameter int N   = 16,
    parameter int W   = 8,
    parameter int LGN = $clog2(N)
) (
    input  logic               clock,
    input  logic               reset,
    spmm_out_buffer_if.slave   bus
);
    localparam int NB = N / 4;
    localparam int BW = LGN - 2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                     state;
    state_t                     state_next;
    logic [N-1:0][N-1:0][W-1:0] mem;
    logic [N-1:0][N-1:0][W-1:0] mem_next;
    logic [N-1:0]               col_mask;
    logic [N-1:0]               mask_next;
    logic [BW-1:0]              beat;
    logic [BW-1:0]              sel;
    logic [3:0][N-1:0][W-1:0]   next_cols;
    logic [3:0][N-1:0][W-1:0]   out_data_q;
    logic                       out_ready_q;
    logic                       out_valid_q;
    logic                       wr_en;
    logic                       start;
    logic                       last_beat;

    function automatic logic [W-1:0] acc(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SPMM_OUTBUF_SAT_EN
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    // in_ready is gated by reset so it reads 0 while reset is held and 1
    // in the very first cycle after release, without waiting for an edge.
    assign bus.in_ready  = reset && (state == FILL);
    assign bus.out_ready = out_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.beat_idx  = beat;

    assign wr_en     = bus.in_valid && bus.in_ready;
    assign start     = (state == FILL) && bus.out_start && out_ready_q;
    assign last_beat = (state == DRAIN) && (beat == LAST_BEAT);

    // Buffer contents after this cycle's write. The first drain beat is
    // taken from here so a write in the out_start cycle reaches the drain.
    always_comb begin
        mem_next  = mem;
        mask_next = col_mask;
        if (wr_en) begin
            for (int r = 0; r < N; r++) begin
                mem_next[bus.in_col][r] = bus.in_os ? acc(mem[bus.in_col][r], bus.in_data[r])
                                                    : bus.in_data[r];
            end
            mask_next[bus.in_col] = 1'b1;
        end
    end

    // Columns for the beat presented after the coming edge.
    always_comb begin
        sel = (state == DRAIN) ? beat + BW'(1) : '0;
        for (int j = 0; j < 4; j++) begin
            next_cols[j] = mem_next[{sel, 2'(j)}];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (start)     state_next = DRAIN;
            DRAIN:   if (last_beat) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // out_ready is registered from the post-write mask, so it rises the
    // cycle after the completing write and falls once the drain starts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem         <= '0;
            col_mask    <= '0;
            out_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            beat        <= '0;
        end else begin
            mem <= mem_next;
            if (start) begin
                col_mask    <= mask_next;
                out_ready_q <= 1'b0;
                out_valid_q <= 1'b1;
                out_data_q  <= next_cols;
                beat        <= '0;
            end else if (state == DRAIN) begin
                if (last_beat) begin
                    col_mask    <= '0;
                    out_valid_q <= 1'b0;
                    beat        <= '0;
                end else begin
                    out_data_q <= next_cols;
                    beat       <= sel;
                end
            end else begin
                col_mask    <= mask_next;
                out_ready_q <= &mask_next;
            end
        end
    end
endmodule

// File: tb/tb_spmm_out_buffer.sv
// Self-checking bench for spmm_out_buffer: directed sequence with random
// column data, compared against a column-array model of the buffer.
module tb_spmm_out_buffer;
    localparam int N   = 16;
    localparam int W   = 8;
    localparam int LGN = $clog2(N);
    localparam int NB  = N / 4;
`ifdef SPMM_OUTBUF_SAT_EN
    localparam int ACC_EXP = 255;
`else
    localparam int ACC_EXP = 44;
`endif

    typedef logic [N-1:0][W-1:0]      col_t;
    typedef logic [3:0][N-1:0][W-1:0] beat_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    spmm_out_buffer_if #(.N(N), .W(W), .LGN(LGN)) bus ();

    spmm_out_buffer #(.N(N), .W(W), .LGN(LGN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    int unsigned model [N][N];
    bit          model_mask [N];
    beat_t       last_beats [NB];

    task automatic check_output(input string tag, input logic [511:0] observed,
                                input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int unsigned model_acc(input int unsigned a, input int unsigned b);
`ifdef SPMM_OUTBUF_SAT_EN
        return (a + b > (1 << W) - 1) ? (1 << W) - 1 : a + b;
`else
        return (a + b) % (1 << W);
`endif
    endfunction

    function automatic bit model_full();
        for (int c = 0; c < N; c++) begin
            if (!model_mask[c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic col_t rand_col();
        col_t d;
        for (int r = 0; r < N; r++) d[r] = W'($urandom);
        return d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            model_mask[c] = 1'b0;
            for (int r = 0; r < N; r++) model[c][r] = 0;
        end
    endtask

    // One column write, held for exactly one cycle.
    task automatic apply_stimulus(input int c, input bit os, input col_t data);
        bus.in_valid = 1'b1;
        bus.in_col   = LGN'(c);
        bus.in_os    = os;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < N; r++) begin
            model[c][r] = os ? model_acc(model[c][r], int'(data[r])) : int'(data[r]);
        end
        model_mask[c] = 1'b1;
    endtask

    // Starts a drain (optionally with a same-cycle overwrite of column wc)
    // and checks every beat against the model; poke drives junk writes
    // during the drain, which must be ignored.
    task automatic run_drain(input bit with_write, input int wc, input col_t wdata,
                             input bit poke);
        beat_t exp;
        bus.out_start = 1'b1;
        if (with_write) begin
            bus.in_valid = 1'b1;
            bus.in_col   = LGN'(wc);
            bus.in_os    = 1'b0;
            bus.in_data  = wdata;
        end
        tick();
        bus.out_start = 1'b0;
        bus.in_valid  = 1'b0;
        if (with_write) begin
            for (int r = 0; r < N; r++) model[wc][r] = int'(wdata[r]);
            model_mask[wc] = 1'b1;
        end
        exp = '0;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < 4; j++) begin
                for (int r = 0; r < N; r++) exp[j][r] = W'(model[4*k+j][r]);
            end
            last_beats[k] = bus.out_data;
            check_output($sformatf("beat%0d_valid", k), 512'(bus.out_valid), 512'(1));
            check_output($sformatf("beat%0d_idx", k), 512'(bus.beat_idx), 512'(k));
            check_output($sformatf("beat%0d_in_ready", k), 512'(bus.in_ready), 512'(0));
            check_output($sformatf("beat%0d_out_ready", k), 512'(bus.out_ready), 512'(0));
            check_output($sformatf("beat%0d_data", k), 512'(bus.out_data), 512'(exp));
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.in_col   = LGN'($urandom_range(0, N - 1));
                bus.in_os    = 1'($urandom);
                bus.in_data  = rand_col();
            end
            tick();
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < N; c++) model_mask[c] = 1'b0;
        check_output("post_drain_valid", 512'(bus.out_valid), 512'(0));
        check_output("post_drain_in_ready", 512'(bus.in_ready), 512'(1));
        check_output("post_drain_out_ready", 512'(bus.out_ready), 512'(0));
        check_output("post_drain_data_hold", 512'(bus.out_data), 512'(exp));
    endtask

    initial begin
        col_t d;
        bus.in_valid  = 1'b0;
        bus.in_col    = '0;
        bus.in_os     = 1'b0;
        bus.in_data   = '0;
        bus.out_start = 1'b0;
        model_clear();

        // Reset held low, then released between edges.
        reset = 1'b0;
        repeat (3) tick();
        check_output("rst_in_ready", 512'(bus.in_ready), 512'(0));
        check_output("rst_out_ready", 512'(bus.out_ready), 512'(0));
        check_output("rst_out_valid", 512'(bus.out_valid), 512'(0));
        check_output("rst_out_data", 512'(bus.out_data), 512'(0));
        check_output("rst_beat_idx", 512'(bus.beat_idx), 512'(0));
        reset = 1'b1;
        #1;
        check_output("rel_in_ready", 512'(bus.in_ready), 512'(1));
        check_output("rel_out_ready", 512'(bus.out_ready), 512'(0));

        // Pass 1: overwrite with c+r.
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) d[r] = W'(c + r);
            apply_stimulus(c, 1'b0, d);
            if (c == N - 2) check_output("p1_not_ready_15", 512'(bus.out_ready), 512'(0));
        end
        check_output("p1_out_ready", 512'(bus.out_ready), 512'(model_full()));
        run_drain(1'b0, 0, '0, 1'b0);
        check_output("p1_b1_d2_r5", 512'(last_beats[1][2][5]), 512'(11));

        // Pass 2: accumulate 1 everywhere.
        for (int r = 0; r < N; r++) d[r] = W'(1);
        for (int c = 0; c < N; c++) apply_stimulus(c, 1'b1, d);
        run_drain(1'b0, 0, '0, 1'b0);
        check_output("p2_b0_d0_r0", 512'(last_beats[0][0][0]), 512'(1));
        check_output("p2_b0_d3_r15", 512'(last_beats[0][3][15]), 512'(19));

        // Pass 3: 200+100 accumulate, incomplete-mask start, same-cycle write.
        d = rand_col();
        d[0] = W'(200);
        apply_stimulus(0, 1'b0, d);
        for (int c = 1; c < N - 1; c++) apply_stimulus(c, 1'($urandom), rand_col());
        d = rand_col();
        d[0] = W'(100);
        apply_stimulus(0, 1'b1, d);
        check_output("p3_not_ready", 512'(bus.out_ready), 512'(model_full()));
        bus.out_start = 1'b1;
        tick();
        bus.out_start = 1'b0;
        check_output("p3_ignored_valid", 512'(bus.out_valid), 512'(0));
        check_output("p3_ignored_in_ready", 512'(bus.in_ready), 512'(1));
        tick();
        check_output("p3_ignored_valid2", 512'(bus.out_valid), 512'(0));
        apply_stimulus(N - 1, 1'b0, rand_col());
        check_output("p3_out_ready", 512'(bus.out_ready), 512'(1));
        for (int r = 0; r < N; r++) d[r] = W'(7);
        run_drain(1'b1, 3, d, 1'b1);
        check_output("p3_acc_200_100", 512'(last_beats[0][0][0]), 512'(ACC_EXP));
        check_output("p3_col3_r0", 512'(last_beats[0][3][0]), 512'(7));
        check_output("p3_col3_r15", 512'(last_beats[0][3][15]), 512'(7));

        // Pass 4: random accumulate; also shows the drain-time pokes did nothing.
        for (int c = 0; c < N; c++) apply_stimulus(c, 1'b1, rand_col());
        run_drain(1'b0, 0, '0, 1'b0);

        // Reset in the middle of a drain.
        for (int c = 0; c < N; c++) apply_stimulus(c, 1'($urandom), rand_col());
        bus.out_start = 1'b1;
        tick();
        bus.out_start = 1'b0;
        check_output("mid_first_beat", 512'(bus.out_valid), 512'(1));
        tick();
        reset = 1'b0;
        #1;
        model_clear();
        check_output("mid_rst_valid", 512'(bus.out_valid), 512'(0));
        check_output("mid_rst_data", 512'(bus.out_data), 512'(0));
        check_output("mid_rst_beat", 512'(bus.beat_idx), 512'(0));
        check_output("mid_rst_in_ready", 512'(bus.in_ready), 512'(0));
        tick();
        check_output("mid_rst_valid2", 512'(bus.out_valid), 512'(0));
        reset = 1'b1;
        #1;
        check_output("mid_rel_in_ready", 512'(bus.in_ready), 512'(1));
        check_output("mid_rel_out_ready", 512'(bus.out_ready), 512'(0));
        tick();
        check_output("mid_rel_valid", 512'(bus.out_valid), 512'(0));

        // Accumulating onto a cleared buffer yields the written data.
        for (int c = 0; c < N; c++) apply_stimulus(c, 1'b1, rand_col());
        run_drain(1'b0, 0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spmm_out_buffer.md
Name: spmm_out_buffer

Overview:
- Output collection stage directly downstream of the PE / reduction unit in the SpMM datapath.
- Captures one N-element result column per accepted transfer into an N x N buffer of data_t, with optional accumulation for output-stationary operation.
- Once all N columns are written, drains the buffer 4 lines per cycle on the SpMM out_ready/out_start handshake.

Parameters:
- N, 16, matrix dimension; power of two, multiple of 4, N >= 4.
- W, 8, element width in bits (data_t).
- LGN, $clog2(N), column index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; buffer and all state cleared while low.
- in_valid  in  1  in_data/in_col/in_os valid this cycle.
- in_ready  out  1  buffer can accept a column.
- in_col  in  LGN  destination column index.
- in_os  in  1  1 = accumulate into stored value; 0 = overwrite.
- in_data  in  N x W  result elements, index = row.
- out_ready  out  1  all N columns written since last drain.
- out_start  in  1  begin drain; honoured only when out_ready=1.
- out_valid  out  1  out_data carries a drain beat.
- out_data  out  4 x N x W  out_data[j][r] = buf[4k+j][r] on beat k.
- beat_idx  out  LGN-2  current drain beat k.

Behaviour:
- Reset (async, active-low): state=FILL, buf all 0, col_mask=0, in_ready=0 while reset low then 1, out_ready=0, out_valid=0, out_data all 0, beat_idx=0.
- States: FILL, DRAIN.
- FILL:
  - in_ready=1.
  - Accept on in_valid & in_ready.
  - At next edge: buf[in_col][r] <= in_os ? buf[in_col][r]+in_data[r] : in_data[r] for all r. Addition wraps modulo 2^W.
  - At the same edge: col_mask[in_col] <= 1.
  - Rewriting an already-written column is legal: overwrite or accumulate per in_os; mask unchanged.
- out_ready is registered: it goes to 1 the cycle after the write that completes col_mask == all-ones, and stays 1 until the drain starts.
- FILL -> DRAIN on out_start & out_ready:
  - in_ready drops the next cycle.
  - An in_valid in the out_start cycle is still accepted, and its data is included in the drain.
- out_start with out_ready=0 is ignored.
- DRAIN:
  - out_valid=1 for exactly N/4 consecutive cycles, beats k=0..N/4-1.
  - First beat is registered, one cycle after out_start.
  - in_ready=0, out_ready=0; in_valid is ignored and nothing is written.
  - out_start is ignored.
- After the last beat:
  - col_mask <= 0, return to FILL; in_ready=1 in the following cycle.
  - out_valid=0, out_data holds its last value.
  - buf contents are retained, so the next pass can accumulate on them (in_os=1).
- Reset mid-DRAIN: immediate abort to the reset state; no further beats.
- Latency: column write to visible buffer is 1 cycle; out_start to first beat is 1 cycle; drain of the full matrix is N/4 cycles.

Optional Feature:
- Macro: SPMM_OUTBUF_SAT_EN.
- Defined: accumulation is unsigned saturating; the sum clamps to 2^W-1 on carry out.
- Undefined: accumulation wraps modulo 2^W.
- Overwrite path is identical in both cases.

Test Plan:
- Reset low mid-operation, then release -> all outputs 0; in_ready=1 first cycle after release; out_ready=0.
- N=16, write cols 0..15 with in_data[r]=c+r, in_os=0 -> out_ready=1 one cycle after col 15; out_start -> 4 beats, beat 1 gives out_data[2][5]=11; in_ready=0 during the beats.
- Second pass with in_os=1, all in_data=1 -> beat 0 gives out_data[0][0]=1, out_data[3][15]=19.
- Accumulate 200+100 with W=8 -> wrap gives 44; with SPMM_OUTBUF_SAT_EN defined gives 255.
- Only 15 columns written, then out_start -> ignored, out_valid stays 0. Write the missing column -> out_ready=1 next cycle.
- in_valid with out_start in the same cycle (col 3 rewritten to 7) -> write accepted; drain beat 0 gives out_data[3][r]=7; in_valid asserted during drain leaves the buffer unchanged.
